// File: rtl/timer_counter_if.sv
// Bus bundle between a timer_counter and whatever drives it (master side
// produces the controls and divided clocks, slave side is the timer itself).
interface timer_counter_if;
  logic [3:0] i_clk_div;
  logic [1:0] i_cks;
  logic       i_en;
  logic       i_up_dn;
  logic       i_load;
  logic [7:0] i_tdr;
  logic       i_ovf_clr;
  logic       i_udf_clr;
  logic [7:0] o_tcnt;
  logic       o_ovf_flag;
  logic       o_udf_flag;
  logic       o_tick;

  modport master (
    output i_clk_div, i_cks, i_en, i_up_dn, i_load, i_tdr, i_ovf_clr, i_udf_clr,
    input  o_tcnt, o_ovf_flag, o_udf_flag, o_tick
  );

  modport slave (
    input  i_clk_div, i_cks, i_en, i_up_dn, i_load, i_tdr, i_ovf_clr, i_udf_clr,
    output o_tcnt, o_ovf_flag, o_udf_flag, o_tick
  );
endinterface

// File: rtl/timer_counter.sv
// 8-bit up/down timer advanced by a rising edge of a selected divided clock,
// with a load path and sticky overflow/underflow flags.
module timer_counter (
  input  logic           i_clk,
  input  logic           i_rst,
  timer_counter_if.slave bus
);

  logic       w_sel;
  logic       w_tick;
  logic       w_step;
  logic       w_wrap_up;
  logic       w_wrap_dn;
  logic       r_sel_q;
  logic [1:0] r_cks_q;
  logic [7:0] r_tcnt;
  logic       r_ovf_flag;
  logic       r_udf_flag;

  // Tick is suppressed whenever the select just changed, so a switch between
  // divided clocks at different levels cannot fake a rising edge.
  always_comb begin
    w_sel     = bus.i_clk_div[bus.i_cks];
    w_tick    = w_sel & ~r_sel_q & (bus.i_cks == r_cks_q) & ~i_rst;
    w_step    = w_tick & bus.i_en & ~bus.i_load;
    w_wrap_up = w_step & bus.i_up_dn & (r_tcnt == 8'hFF);
    w_wrap_dn = w_step & ~bus.i_up_dn & (r_tcnt == 8'h00);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel_q    <= 1'b0;
      r_cks_q    <= 2'd0;
      r_tcnt     <= 8'h00;
      r_ovf_flag <= 1'b0;
      r_udf_flag <= 1'b0;
    end else begin
      r_sel_q    <= w_sel;
      r_cks_q    <= bus.i_cks;
      // A set in the same cycle as a clear keeps the flag high.
      r_ovf_flag <= w_wrap_up | (r_ovf_flag & ~bus.i_ovf_clr);
      r_udf_flag <= w_wrap_dn | (r_udf_flag & ~bus.i_udf_clr);
      if (bus.i_load) begin
        r_tcnt <= bus.i_tdr;
      end else if (w_step) begin
        if (bus.i_up_dn) begin
          r_tcnt <= r_tcnt + 8'd1;
        end else begin
          r_tcnt <= r_tcnt - 8'd1;
        end
      end else begin
        r_tcnt <= r_tcnt;
      end
    end
  end

  assign bus.o_tcnt     = r_tcnt;
  assign bus.o_ovf_flag = r_ovf_flag;
  assign bus.o_udf_flag = r_udf_flag;
  assign bus.o_tick     = w_tick;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: fixed vector table, directed corner sequences and
// random stimulus, all compared against an arithmetic reference model.
module tb_timer_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] div_cnt;
  int         passed = 0;
  int         total  = 0;

  int         m_cnt;
  bit         m_ovf, m_udf, m_prev_sel;
  logic [1:0] m_prev_cks;

  typedef struct {
    bit         rst, load;
    logic [7:0] tdr;
    bit         en, up;
    logic [1:0] cks;
    bit         oclr, uclr;
    bit         e_tick;
    logic [7:0] e_cnt;
    bit         e_ovf, e_udf;
  } vec_t;

  vec_t tbl[29];

  always #5 clk = ~clk;

  timer_counter_if bus();
  assign bus.i_clk_div = div_cnt;

  timer_counter dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: check tick before the edge, advance the model, check state after.
  task automatic step(output bit seen_tick);
    bit sel, etick, oset, uset;
    #2;
    sel   = div_cnt[bus.i_cks];
    etick = !rst && sel && !m_prev_sel && (bus.i_cks == m_prev_cks);
    seen_tick = bus.o_tick;
    check("tick", int'(bus.o_tick), int'(etick));
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_ovf = 0; m_udf = 0; m_prev_sel = 0; m_prev_cks = 2'd0;
    end else begin
      m_prev_sel = sel;
      m_prev_cks = bus.i_cks;
      oset = 0; uset = 0;
      if (bus.i_load) m_cnt = int'(bus.i_tdr);
      else if (bus.i_en && etick) begin
        if (bus.i_up_dn) begin
          oset  = (m_cnt == 255);
          m_cnt = (m_cnt + 1) % 256;
        end else begin
          uset  = (m_cnt == 0);
          m_cnt = (m_cnt + 255) % 256;
        end
      end
      m_ovf = oset || (m_ovf && !bus.i_ovf_clr);
      m_udf = uset || (m_udf && !bus.i_udf_clr);
    end
    #1;
    div_cnt = div_cnt + 4'd1;
    check("tcnt", int'(bus.o_tcnt), m_cnt);
    check("ovf_flag", int'(bus.o_ovf_flag), int'(m_ovf));
    check("udf_flag", int'(bus.o_udf_flag), int'(m_udf));
  endtask

  task automatic drive(input bit r, input bit ld, input logic [7:0] d, input bit e,
                       input bit u, input logic [1:0] c, input bit oc, input bit uc);
    rst = r; bus.i_load = ld; bus.i_tdr = d; bus.i_en = e; bus.i_up_dn = u;
    bus.i_cks = c; bus.i_ovf_clr = oc; bus.i_udf_clr = uc;
  endtask

  initial begin
    bit t;
    int ticks, last, gap_ok;
    logic [1:0] rc;

    m_cnt = 0; m_ovf = 0; m_udf = 0; m_prev_sel = 0; m_prev_cks = 2'd0;
    div_cnt = 4'd0;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    //          rst   load  tdr    en    up    cks   oclr  uclr  tick  cnt    ovf   udf
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'hFE, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    for (int i = 22; i < 28; i++)
      tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[28] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].rst, tbl[i].load, tbl[i].tdr, tbl[i].en, tbl[i].up, tbl[i].cks,
            tbl[i].oclr, tbl[i].uclr);
      step(t);
      check($sformatf("vec%0d tick", i), int'(t), int'(tbl[i].e_tick));
      check($sformatf("vec%0d tcnt", i), int'(bus.o_tcnt), int'(tbl[i].e_cnt));
      check($sformatf("vec%0d ovf", i), int'(bus.o_ovf_flag), int'(tbl[i].e_ovf));
      check($sformatf("vec%0d udf", i), int'(bus.o_udf_flag), int'(tbl[i].e_udf));
    end

    // Reset mid-count at 8'h37 with both flags set.
    drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0); step(t);
    bus.i_load = 1'b0;
    for (int i = 0; i < 4; i++) step(t);
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0); step(t);
    bus.i_load = 1'b0;
    for (int i = 0; i < 4; i++) step(t);
    drive(1'b0, 1'b1, 8'h37, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0); step(t);
    check("pre-rst tcnt", int'(bus.o_tcnt), 32'h37);
    check("pre-rst ovf", int'(bus.o_ovf_flag), 1);
    check("pre-rst udf", int'(bus.o_udf_flag), 1);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0); step(t);
    check("rst tcnt", int'(bus.o_tcnt), 0);
    check("rst ovf", int'(bus.o_ovf_flag), 0);
    check("rst udf", int'(bus.o_udf_flag), 0);

    // en low for 32 cycles holds the count.
    drive(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0); step(t);
    bus.i_load = 1'b0;
    for (int i = 0; i < 32; i++) step(t);
    check("en0 hold", int'(bus.o_tcnt), 32'hA5);

    // Prescale /16: tick spacing exactly 16, about 10 counts in 160 cycles.
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0); step(t); step(t);
    rst = 1'b0;
    ticks = 0; last = -1; gap_ok = 1;
    for (int i = 0; i < 160; i++) begin
      step(t);
      if (t) begin
        if (last >= 0 && (i - last) != 16) gap_ok = 0;
        last = i;
        ticks++;
      end
    end
    check("div16 tick gap", gap_ok, 1);
    check("div16 tcnt range", int'(bus.o_tcnt >= 8'h09 && bus.o_tcnt <= 8'h0B), 1);
    check("div16 tick count", int'(bus.o_tcnt), ticks);

    // Random stimulus against the model.
    rc = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) rc = 2'($urandom_range(3));
      drive($urandom_range(63) == 0, $urandom_range(15) == 0, 8'($urandom_range(255)),
            $urandom_range(3) != 0, 1'($urandom_range(1)), rc,
            $urandom_range(7) == 0, $urandom_range(7) == 0);
      step(t);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

8-bit up/down timer counter clocked by `clk` and advanced by a selectable divided-clock tick. It sits directly downstream of the clock divider. It consumes the divider's four divided clock outputs (÷2, ÷4, ÷8, ÷16), all synchronous to `clk`. It selects one of them, converts its rising edge into a single-cycle count enable, and maintains the timer count with a load path and sticky overflow/underflow flags.

## Interface
- No parameters; width fixed at 8 bits.
- `clk`  in  1  system clock. The same clock drives the divider.
- `rst`  in  1  synchronous reset, active-high.
- `clk_div`  in  4  divided clocks: [0]=÷2, [1]=÷4, [2]=÷8, [3]=÷16. Synchronous to `clk`.
- `cks`  in  2  clock select: 0=÷2, 1=÷4, 2=÷8, 3=÷16.
- `en`  in  1  count enable. When 0, ticks are ignored and `tcnt` holds.
- `up_dn`  in  1  1=count up, 0=count down.
- `load`  in  1  load `tdr` into `tcnt` on this cycle.
- `tdr`  in  8  load value.
- `ovf_clr`  in  1  clear `ovf_flag`.
- `udf_clr`  in  1  clear `udf_flag`.
- `tcnt`  out  8  current count.
- `ovf_flag`  out  1  sticky overflow flag (up-count wrap FF→00).
- `udf_flag`  out  1  sticky underflow flag (down-count wrap 00→FF).
- `tick`  out  1  internal count strobe, exported for debug/verification.

## Operation
- **Reset:** `rst`=1 at a `clk` rising edge gives `tcnt`=8'h00, `ovf_flag`=0, `udf_flag`=0, `tick`=0, internal `sel_q`=0, internal `cks_q`=0.
- **Select:** `sel` = `clk_div[cks]` (combinational).
- **Edge detection:**
  - `sel_q` is `sel` registered every cycle.
  - `cks_q` is `cks` registered every cycle.
  - Raw edge = `sel` & ~`sel_q`.
- **Tick:** `tick` = raw edge & (`cks` == `cks_q`) & ~`rst`. A tick is suppressed in any cycle where `cks` differs from last cycle's value, so switching the select never produces a spurious count.
- **Tick rate:** with `clk_div` free-running, `tick` pulses once every 2/4/8/16 `clk` cycles for `cks`=0/1/2/3. Each pulse is exactly 1 cycle wide.
- **Count update priority**, per cycle:
  1. `rst`.
  2. `load`: `tcnt` ← `tdr`. Flags untouched. A tick in the same cycle is discarded.
  3. `en` & `tick` & `up_dn`: `tcnt` ← `tcnt`+1, modulo 256. If `tcnt` was 8'hFF, set `ovf_flag`.
  4. `en` & `tick` & ~`up_dn`: `tcnt` ← `tcnt`−1, modulo 256. If `tcnt` was 8'h00, set `udf_flag`.
  5. Otherwise hold.
- **Flags:**
  - Sticky; cleared only by `rst` or by the respective `*_clr`.
  - Set and clear in the same cycle: set wins, flag stays 1.
  - `ovf_clr` does not affect `udf_flag`, and vice versa.
- **Direction change:** `up_dn` may change at any cycle. It takes effect on the next tick. No flag is set by the change itself.
- **No saturation:** counting always wraps.

## Timing
- Everything is registered on `clk` rising edge; no combinational path from inputs to `tcnt` or flags.
- `tick` is asserted in the cycle where `sel` is first seen high.
  - `tcnt` reflects the increment/decrement at the following rising edge: 1-cycle latency from `tick` to `tcnt`.
  - The flag sets on that same edge.
- `load`: `tcnt`=`tdr` visible 1 cycle after `load` is sampled high.
- `*_clr`: flag reads 0 one cycle after the clear is sampled, unless it is set in the same cycle.
- **Reset mid-operation:** all state returns to reset values on the next edge.
  - The first tick after `rst` deasserts requires a fresh 0→1 transition of `sel`. Because `sel_q` resets to 0, a `sel` that is already high immediately after reset produces one tick.
- **`en` deasserted:** a tick occurring while `en`=0 is lost, not deferred.

## Test plan
- **Reset/basic count:** `rst` for 2 cycles; `cks`=0, `en`=1, `up_dn`=1; run 20 `clk` cycles → `tcnt` increments by 1 every 2 cycles, reaching 8'h0A (±1 for phase); flags 0.
- **Prescale:** `cks`=3, `en`=1, up, start at 0; run 160 cycles → `tcnt`=8'h0A (±1); `tick` period exactly 16 cycles.
- **Overflow:** load `tdr`=8'hFE, `cks`=0, up → after 2 ticks `tcnt`=8'h00 and `ovf_flag`=1. Assert `ovf_clr` on the same cycle as a new overflow → flag stays 1. Assert `ovf_clr` alone → flag 0 next cycle.
- **Underflow:** load 8'h01, down → after 2 ticks `tcnt`=8'hFF, `udf_flag`=1, `ovf_flag`=0.
- **Priority/hold:**
  - `load`=1 with `tdr`=8'h55 in a tick cycle → `tcnt`=8'h55, not 8'h56.
  - `en`=0 for 32 cycles → `tcnt` unchanged.
- **Select switch and reset:**
  - Change `cks` 0→2 while `clk_div[2]` is rising → no tick that cycle; subsequent ticks every 8 cycles.
  - Assert `rst` mid-count at 8'h37 with both flags set → `tcnt`=0 and flags 0 on the next edge.
